// File: rtl/fmap_writer.sv
// fmap_writer: write-back end of a layer.
// Buffers each incoming per-pixel vector in a small FIFO and serialises it
// lane by lane into a single-port feature-map SRAM using a planar layout
// (plane-major, then row, then column).
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   go            one-cycle frame start pulse (ignored unless idle)
//   in_en/in_data input vector stream, channel 0 in the MSB lane
//   mem_gnt       memory accepts the current write
//   mem_wen/mem_addr/mem_wdata  registered write request
//   busy, done    frame in progress / one-cycle frame-complete pulse
//   overflow      sticky: a vector was dropped on a full FIFO
//   stray         sticky: in_en seen while idle
//   fifo_level    current FIFO occupancy
module fmap_writer #(
  parameter int unsigned CHANNELS   = 6,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned OUT_WIDTH  = 28,
  parameter int unsigned OUT_HEIGHT = 28,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         go,
  input  logic                         in_en,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  input  logic                         mem_gnt,
  output logic                         mem_wen,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow,
  output logic                         stray,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int unsigned VEC_W = CHANNELS * DATA_W;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CH_W  = (CHANNELS   > 1) ? $clog2(CHANNELS)   : 1;
  localparam int unsigned COL_W = (OUT_WIDTH  > 1) ? $clog2(OUT_WIDTH)  : 1;
  localparam int unsigned ROW_W = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;

  localparam logic [ADDR_W-1:0] PLANE_SZ = ADDR_W'(OUT_WIDTH * OUT_HEIGHT);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [VEC_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [VEC_W-1:0]  fifo_head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;

  logic [VEC_W-1:0]  shadow;
  logic [CH_W-1:0]   ch;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] pix_addr;
  logic [DATA_W-1:0] lane_nxt;

  logic start, accept, last_lane, last_col, last_pix, pixel_done, frame_end;
  logic ser_free, fifo_empty, fifo_full, pop, push_req, push, drop;

  assign fifo_level = level;
  assign fifo_head  = fifo_mem[rd_ptr];

  assign start      = (state == S_IDLE) && go;
  assign accept     = mem_wen && mem_gnt;
  assign last_lane  = (ch  == CH_W'(CHANNELS - 1));
  assign last_col   = (col == COL_W'(OUT_WIDTH - 1));
  assign last_pix   = last_col && (row == ROW_W'(OUT_HEIGHT - 1));
  assign pixel_done = accept && last_lane;
  assign frame_end  = pixel_done && last_pix;

  // Serializer can take a new vector when empty, or in the same cycle its
  // last lane is accepted (unless that lane ends the frame).
  assign ser_free   = !mem_wen || (pixel_done && !last_pix);
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
  assign pop        = (state == S_RUN) && ser_free && !fifo_empty;
  assign push_req   = in_en && (state != S_IDLE);
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  always_comb begin
    lane_nxt = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (CH_W'(i) == ch + CH_W'(1))
        lane_nxt = shadow[(CHANNELS-1-i)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (go) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (frame_end) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_data;
  end

  // Addresses are kept incrementally: pix_addr tracks BASE + row*W + col,
  // and each further lane adds one plane size to the current address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      stray     <= 1'b0;
      shadow    <= '0;
      ch        <= '0;
      col       <= '0;
      row       <= '0;
      pix_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (start) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      stray    <= 1'b0;
      ch       <= '0;
      col      <= '0;
      row      <= '0;
      pix_addr <= BASE_A;
      mem_wen  <= 1'b0;
    end else begin
      if (in_en && (state == S_IDLE)) stray <= 1'b1;
      if (drop) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(push) - LVL_W'(pop);

      if (pixel_done) begin
        if (last_pix) begin
          col      <= '0;
          row      <= '0;
          pix_addr <= BASE_A;
        end else begin
          pix_addr <= pix_addr + ADDR_W'(1);
          if (last_col) begin
            col <= '0;
            row <= row + ROW_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end
        end
      end

      if (pop) begin
        shadow    <= fifo_head;
        ch        <= '0;
        mem_wen   <= 1'b1;
        mem_wdata <= fifo_head[VEC_W-1 -: DATA_W];
        mem_addr  <= pixel_done ? pix_addr + ADDR_W'(1) : pix_addr;
      end else if (accept) begin
        if (last_lane) begin
          mem_wen <= 1'b0;
          ch      <= '0;
        end else begin
          ch        <= ch + CH_W'(1);
          mem_addr  <= mem_addr + PLANE_SZ;
          mem_wdata <= lane_nxt;
        end
      end
    end
  end

endmodule
